// File: rtl/mips_mem_pkg.sv
// Shared MEM-stage definitions: access size encodings, access FSM states, byte-enable patterns,
// and the store lane formatting helpers.
package mips_mem_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;

  typedef enum logic {IDLE, BUSY} mem_state_e;

  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: store_be = BE_BYTE0 << lo;
      SZ_HALF: store_be = lo[1] ? BE_HALF_HI : BE_HALF_LO;
      default: store_be = BE_WORD;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] src);
    case (size)
      SZ_BYTE: store_wdata = {4{src[7:0]}};
      SZ_HALF: store_wdata = {2{src[15:0]}};
      default: store_wdata = src;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Picks the addressed byte/half lane out of a 32-bit read word and sign/zero extends it.
// Purely combinational, zero latency, no flow control.
module mem_load_align
  import mips_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        sign,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_BYTE: data = {{24{sign & byte_sel[7]}}, byte_sel};
      SZ_HALF: data = {{16{sign & half_sel[15]}}, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: runs load/store on a req/ack data bus and registers the MEM/WB result; 1 cycle
// for non-memory ops, 2 + ack wait for accesses; mem_stall holds upstream while an access is open.
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        MEM_inst_en,
  input  logic [31:0] MEM_ALU_Result,
  input  logic [31:0] MEM_Src2,
  input  logic [4:0]  MEM_Rdst,
  input  logic        MEM_RegW,
  input  logic        MEM_MemR,
  input  logic        MEM_MemW,
  input  logic [1:0]  MEM_SelMOD,
  input  logic        MEM_MdataS,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        WB_inst_en,
  output logic [31:0] WB_Result,
  output logic [4:0]  WB_Rdst,
  output logic        WB_RegW,
  output logic        misalign_exc,
  output logic        bus_err
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  mem_state_e       state, state_nxt;
  logic             kill;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       lane_q, size_q;
  logic             sign_q, regw_q;
  logic [4:0]       rdst_q;
  logic [31:0]      ld_data;

  logic access, misaligned, start, timeout;

  assign access     = MEM_inst_en & (MEM_MemR | MEM_MemW);
  assign misaligned = ((MEM_SelMOD == SZ_HALF) & MEM_ALU_Result[0]) |
                      ((MEM_SelMOD != SZ_HALF) & (MEM_SelMOD != SZ_BYTE) & (MEM_ALU_Result[1:0] != 2'b00));
  assign start      = (state == IDLE) & access & ~misaligned & ~flush;
  assign timeout    = (state == BUSY) & ~dmem_ack & (cnt == CNT_W'(ACK_TIMEOUT - 1));

  mem_load_align u_align (
    .rdata (dmem_rdata),
    .size  (size_q),
    .lane  (lane_q),
    .sign  (sign_q),
    .data  (ld_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Stall drops on the ack/timeout cycle so upstream advances on the same edge as WB.
  always_comb begin
    state_nxt = state;
    mem_stall = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_nxt = BUSY;
        mem_stall = 1'b1;
      end
      BUSY: if (dmem_ack || timeout) state_nxt = IDLE;
            else                     mem_stall = 1'b1;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      dmem_be      <= '0;
      WB_inst_en   <= 1'b0;
      WB_Result    <= '0;
      WB_Rdst      <= '0;
      WB_RegW      <= 1'b0;
      misalign_exc <= 1'b0;
      bus_err      <= 1'b0;
      kill         <= 1'b0;
      cnt          <= '0;
      lane_q       <= '0;
      size_q       <= '0;
      sign_q       <= 1'b0;
      regw_q       <= 1'b0;
      rdst_q       <= '0;
    end else begin
      misalign_exc <= (state == IDLE) & access & misaligned & ~flush;
      bus_err      <= timeout;
      WB_inst_en   <= 1'b0;
      WB_Result    <= '0;
      WB_Rdst      <= '0;
      WB_RegW      <= 1'b0;
      case (state)
        IDLE: begin
          kill <= 1'b0;
          if (start) begin
            dmem_req   <= 1'b1;
            dmem_we    <= MEM_MemW;
            dmem_addr  <= {MEM_ALU_Result[31:2], 2'b00};
            dmem_wdata <= store_wdata(MEM_SelMOD, MEM_Src2);
            dmem_be    <= MEM_MemW ? store_be(MEM_SelMOD, MEM_ALU_Result[1:0]) : BE_WORD;
            lane_q     <= MEM_ALU_Result[1:0];
            size_q     <= MEM_SelMOD;
            sign_q     <= MEM_MdataS;
            regw_q     <= MEM_RegW & ~MEM_MemW;
            rdst_q     <= MEM_Rdst;
            cnt        <= '0;
          end else if (!flush && !access) begin
            WB_inst_en <= MEM_inst_en;
            WB_Result  <= MEM_ALU_Result;
            WB_Rdst    <= MEM_Rdst;
            WB_RegW    <= MEM_RegW;
          end
        end
        BUSY: begin
          if (dmem_ack || timeout) begin
            dmem_req <= 1'b0;
            kill     <= 1'b0;
            if (dmem_ack && !(kill || flush)) begin
              WB_inst_en <= 1'b1;
              WB_Result  <= dmem_we ? 32'b0 : ld_data;
              WB_Rdst    <= rdst_q;
              WB_RegW    <= regw_q;
            end
          end else begin
            cnt <= cnt + 1'b1;
            if (flush) kill <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs: performs the data-memory access for loads/stores over a req/ack bus.
- Formats store data and byte enables; extracts and extends load data; registers the writeback result (MEM/WB boundary).
- Drives mem_stall back to the pipeline control, which feeds the Stall input of the EX/MEM and earlier registers while an access is outstanding.

Parameters:
- ACK_TIMEOUT, 255, cycles in BUSY without dmem_ack before the access is abandoned with bus_err.
- CNT_W, $clog2(ACK_TIMEOUT+1), timeout counter width (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  squash the current MEM-stage instruction.
- MEM_inst_en  in  1  valid instruction in MEM.
- MEM_ALU_Result  in  32  ALU result / effective address.
- MEM_Src2  in  32  store data.
- MEM_Rdst  in  5  destination register.
- MEM_RegW  in  1  register write enable.
- MEM_MemR  in  1  load.
- MEM_MemW  in  1  store.
- MEM_SelMOD  in  2  size: 00 word, 01 half, 10 byte, 11 treated as word.
- MEM_MdataS  in  1  load extension: 1 sign, 0 zero.
- dmem_req  out  1  bus request, held until ack or timeout.
- dmem_we  out  1  1 = write.
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- dmem_wdata  out  32  lane-replicated store data.
- dmem_be  out  4  byte enables, bit i = byte lane i (little-endian).
- dmem_ack  in  1  bus completion, sampled only in BUSY.
- dmem_rdata  in  32  read data, valid with dmem_ack.
- mem_stall  out  1  combinational stall request to the pipeline.
- WB_inst_en  out  1  valid instruction in WB.
- WB_Result  out  32  writeback data.
- WB_Rdst  out  5  writeback register.
- WB_RegW  out  1  writeback enable.
- misalign_exc  out  1  one-cycle pulse: misaligned access.
- bus_err  out  1  one-cycle pulse: ack timeout.

Behaviour:
- Reset (async): state IDLE; all registered outputs 0: dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, WB_*, misalign_exc, bus_err; kill bit and counter 0.
- access = MEM_inst_en & (MEM_MemR | MEM_MemW). misaligned = (half & addr[0]) | (word & addr[1:0]!=0).
- States: IDLE, BUSY.
- IDLE, no access (or flush): next edge loads WB from inputs (WB_Result = ALU_Result), no stall. On flush, WB loads a bubble (all WB_* = 0).
- IDLE, access & misaligned & !flush: no request; next edge misalign_exc=1 for one cycle; WB bubble; no stall.
- IDLE, access & aligned & !flush:
  - mem_stall=1.
  - Next edge: latch dmem_addr/we/wdata/be, Rdst, RegW (forced 0 for stores), size, sign; dmem_req=1; counter=0; go BUSY.
- BUSY, mem_stall = !dmem_ack; upstream inputs are held by the stall.
  - On ack: next edge drops dmem_req, loads WB (load: extracted data; store: WB_RegW=0, WB_inst_en=1), and goes IDLE. Upstream advances on the same edge.
  - No ack: counter increments.
  - On counter==ACK_TIMEOUT-1 without ack: next edge drops req, bus_err pulse, WB bubble, IDLE, stall released.
- flush in BUSY: transaction is not aborted. Set kill bit; on completion WB loads a bubble. Kill clears on return to IDLE.
- Store formatting:
  - byte: wdata = {4{Src2[7:0]}}, be = 1<<addr[1:0].
  - half: wdata = {2{Src2[15:0]}}, be = addr[1] ? 1100 : 0011.
  - word: wdata = Src2, be = 1111.
  - Loads: be = 1111, we = 0.
- Load extract:
  - byte: lane addr[1:0].
  - half: lane addr[1].
  - Extend to 32 bits per latched sign bit.
- Latency:
  - Non-memory instruction: 1 cycle.
  - Memory access: 2 + (ack wait) cycles; minimum 2, with ack on the first BUSY cycle.
- Reset mid-BUSY: immediate return to IDLE, req dropped, no WB write.

Decomposition:
- Shared package mips_mem_pkg:
  - SelMOD encodings SZ_WORD/SZ_HALF/SZ_BYTE.
  - State enum IDLE/BUSY.
  - Byte-enable constants.
- One sub-module: mem_load_align (combinational lane select plus sign/zero extension), reused later by any cache refill path.

Test Plan:
- Non-mem ALU op, ALU_Result=0x1234_5678, Rdst=5, RegW=1 -> one edge later WB_Result=0x12345678, WB_Rdst=5, WB_RegW=1, mem_stall never 1.
- lb, signed, addr=0x103, rdata=0x80FF_0000, ack after 3 wait cycles -> dmem_addr=0x100, be=1111, mem_stall high 4 cycles, WB_Result=0xFFFFFF80.
- sh, addr=0x202, Src2=0xAAAA_BEEF, ack immediately -> wdata=0xBEEFBEEF, be=1100, we=1, then WB_RegW=0, WB_inst_en=1.
- lw at addr=0x301 -> dmem_req stays 0, misalign_exc one-cycle pulse, WB bubble.
- Load with flush asserted in second BUSY cycle, ack at fourth -> req held until ack, WB_inst_en=0, WB_RegW=0.
- ACK_TIMEOUT=4, no ack -> req dropped after 4 BUSY cycles, bus_err pulse, mem_stall released; assert rst mid-BUSY -> all outputs 0 asynchronously.
